kbd_scan_ctrl: RTL and testbench
================================

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, number of buffered scan bytes (power of two, >=2).
REQ-002 The ports SHALL be, in order:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- byte_valid  in  1  one-cycle strobe from the PS/2 receiver, byte_data valid
- byte_data  in  8  received scan byte
- ev_ready  in  1  consumer accepts the event this cycle
- ovf_clr  in  1  clears the sticky overflow flag
- ev_valid  out  1  key event pending
- ev_code  out  8  event scan code, prefixes removed
- ev_ext  out  1  event carried an E0 prefix
- ev_break  out  1  event is a release
- ev_repeat  out  1  make event is a typematic repeat of the held key
- cur_code  out  8  code of the most recently pressed key, for display
- key_held  out  1  cur_code key is currently down; display blanks when 0
- press_count  out  8  count of non-repeat make events
- overflow  out  1  sticky; a byte was dropped

Function
REQ-003 The input FIFO SHALL write byte_data on every byte_valid when not full, or when full and a pop occurs in the same cycle.
REQ-004 byte_valid while the FIFO is full with no pop SHALL drop the byte and set overflow; the FIFO SHALL stay unchanged.
REQ-005 overflow SHALL clear on ovf_clr; simultaneous set and ovf_clr SHALL leave overflow at 1.
REQ-006 The decoder SHALL pop one byte per cycle when the FIFO is non-empty and not stalled.
REQ-007 The decoder SHALL be stalled when ev_valid=1 and ev_ready=0.
REQ-008 The decoder state machine SHALL have states IDLE, BRK, EXT and EXT_BRK.
REQ-009 Popped 0xF0 SHALL move IDLE->BRK and EXT->EXT_BRK, and leave BRK and EXT_BRK unchanged.
REQ-010 Popped 0xE0 SHALL move any state to EXT (resync), with no event.
REQ-011 Popped 0xAA, 0xFA, 0xEE or 0xFE in IDLE SHALL be discarded with no event and no state change.
REQ-012 Any other popped byte SHALL produce one event and return the state machine to IDLE.
- ev_ext=1 in EXT or EXT_BRK.
- ev_break=1 in BRK or EXT_BRK.
REQ-013 For a make event matching {cur_code,ext} while key_held=1, the block SHALL set ev_repeat=1 and leave press_count unchanged.
REQ-014 Any other make event SHALL set ev_repeat=0, load cur_code and the held extension bit, set key_held=1, and increment press_count modulo 256 (255->0).
REQ-015 A break event matching {cur_code,ext} SHALL clear key_held; a non-matching break SHALL leave cur_code and key_held unchanged.
- Break events always have ev_repeat=0.
REQ-016 The event register SHALL load when empty or when accepted (ev_valid & ev_ready) in the same cycle, giving one event per cycle of throughput.
REQ-017 ev_code, ev_ext, ev_break and ev_repeat SHALL be held stable while ev_valid=1 and ev_ready=0.
REQ-018 Latency SHALL be as follows for a byte_valid in cycle N into an empty FIFO with no stall:
- byte is popped in N+1;
- ev_valid, cur_code, key_held and press_count update visibly in N+2.
REQ-019 cur_code, key_held and press_count SHALL update in the pop cycle, independent of ev_ready.

Reset
REQ-020 On clr=0 the block SHALL asynchronously:
- empty the FIFO and set the state machine to IDLE;
- drive ev_valid, ev_code, ev_ext, ev_break, ev_repeat, cur_code, key_held, press_count and overflow to 0.
REQ-021 Reset mid-sequence (e.g. after 0xE0) SHALL discard the partial prefix; the first post-reset byte SHALL decode from IDLE.
REQ-022 Release of clr SHALL be synchronous to clk; the first byte_valid is accepted in the first cycle after release.

Verification
REQ-023 Bytes 0x1C, then 0xF0, 0x1C, with ev_ready=1 -> expected response:
- make event code 0x1C, ext=0: press_count=1, key_held=1, cur_code=0x1C;
- break event code 0x1C: key_held=0.
REQ-024 Bytes 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> expected response:
- events {0x75, ext=1, break=0} then {0x75, ext=1, break=1};
- exactly two ev_valid cycles.
REQ-025 Bytes 0x1C, 0x1C, 0x1C (typematic) -> expected response:
- three events, ev_repeat=0,1,1;
- press_count=1.
REQ-026 ev_ready held 0 with 6 back-to-back make bytes, FIFO_DEPTH=4 -> expected response:
- first event held stable;
- FIFO fills and overflow=1;
- after ev_ready=1, remaining buffered events emerge in order with none duplicated.
REQ-027 press_count=255 (255 distinct make/break pairs), then make 0x2A -> expected response:
- press_count=0;
- ovf_clr then clears overflow.
REQ-028 clr=0 pulse after byte 0xE0, then byte 0x75 -> expected response:
- all outputs 0 during reset;
- event {0x75, ext=0}.

Source files
------------

// File: rtl/kbd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_scan_ctrl
//
// Turns the raw PS/2 scan byte stream into key events.
//
// Bytes from the PS/2 receiver land in a small FIFO. A decoder pops one byte
// per cycle, strips the E0 (extended) and F0 (break) prefixes, discards
// keyboard housekeeping replies (AA/FA/EE/FE), and emits one event per key
// code. The decoder also tracks the most recently pressed key for a display,
// counts fresh key presses and flags typematic repeats.
//
// Ports
//   clk          system clock, all state on the rising edge
//   clr          asynchronous active-low reset
//   byte_valid   one-cycle strobe, byte_data holds a received scan byte
//   byte_data    received scan byte
//   ev_ready     consumer accepts the pending event this cycle
//   ovf_clr      clears the sticky overflow flag
//   ev_valid     key event pending
//   ev_code      event scan code with prefixes removed
//   ev_ext       event carried an E0 prefix
//   ev_break     event is a key release
//   ev_repeat    make event is a typematic repeat of the held key
//   cur_code     code of the most recently pressed key
//   key_held     cur_code key is still down (display blanks when 0)
//   press_count  count of non-repeat make events, wraps 255 -> 0
//   overflow     sticky, a byte was dropped because the FIFO was full
//
// Event handshake: an event is transferred on every rising edge where
// ev_valid and ev_ready are both 1. While ev_valid=1 and ev_ready=0 the
// event fields are frozen and the decoder pops nothing. ev_ready may be
// asserted without ev_valid; the event register refills in the same cycle
// it is drained, so a steady ev_ready gives one event per cycle.
//
// The byte input has no backpressure: a byte offered while the FIFO is full
// and nothing is being popped is lost and sets overflow.
// ---------------------------------------------------------------------------
module kbd_scan_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic       ev_ready,
   input  logic       ovf_clr,
   output logic       ev_valid,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ev_repeat,
   output logic [7:0] cur_code,
   output logic       key_held,
   output logic [7:0] press_count,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } dec_state_t;

   // ------------------------------------------------------------------------
   // Input FIFO. Pointers carry one extra wrap bit so full and empty can be
   // told apart without a separate counter.
   // ------------------------------------------------------------------------
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        fifo_empty;
   logic        fifo_full;
   logic        pop;
   logic        push;
   logic        drop;
   logic [7:0]  head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head       = mem[rd_ptr[AW-1:0]];

   // The decoder only moves when the event register can take a new event,
   // so a popped byte never has to wait anywhere.
   assign pop  = !fifo_empty && !(ev_valid && !ev_ready);

   // A full FIFO still accepts a byte when a slot frees in the same cycle.
   assign push = byte_valid && (!fifo_full || pop);
   assign drop = byte_valid && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= byte_data;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Setting wins over clearing so a drop in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Prefix decoder state machine
   // ------------------------------------------------------------------------
   dec_state_t state;
   dec_state_t state_nxt;
   logic       gen_ev;
   logic       nxt_ext;
   logic       nxt_brk;

   function automatic logic is_reply(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) || (b == 8'hFE);
   endfunction

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gen_ev    = 1'b0;
      nxt_ext   = (state == EXT) || (state == EXT_BRK);
      nxt_brk   = (state == BRK) || (state == EXT_BRK);
      if (pop) begin
         if (head == CODE_BRK) begin
            // A repeated F0 changes nothing; the break is already noted.
            case (state)
               IDLE:    state_nxt = BRK;
               EXT:     state_nxt = EXT_BRK;
               default: state_nxt = state;
            endcase
         end else if (head == CODE_EXT) begin
            // E0 always restarts a sequence, which resyncs after garbage.
            state_nxt = EXT;
         end else if ((state == IDLE) && is_reply(head)) begin
            state_nxt = IDLE;
         end else begin
            // Inside a prefix sequence every other byte is a key code,
            // including values that look like keyboard replies.
            gen_ev    = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Key tracking and event register
   // ------------------------------------------------------------------------
   logic cur_ext;
   logic key_match;
   logic is_repeat;

   // Keys are identified by code plus extension bit: E0 75 and 75 are
   // different keys.
   assign key_match = (head == cur_code) && (nxt_ext == cur_ext);
   assign is_repeat = !nxt_brk && key_held && key_match;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ev_valid  <= 1'b0;
         ev_code   <= 8'h00;
         ev_ext    <= 1'b0;
         ev_break  <= 1'b0;
         ev_repeat <= 1'b0;
      end else if (gen_ev) begin
         ev_valid  <= 1'b1;
         ev_code   <= head;
         ev_ext    <= nxt_ext;
         ev_break  <= nxt_brk;
         ev_repeat <= is_repeat;
      end else if (ev_ready) begin
         ev_valid  <= 1'b0;
      end
   end

   // Display tracking follows the pop, not the consumer handshake.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cur_code    <= 8'h00;
         cur_ext     <= 1'b0;
         key_held    <= 1'b0;
         press_count <= 8'h00;
      end else if (gen_ev) begin
         if (!nxt_brk && !is_repeat) begin
            cur_code    <= head;
            cur_ext     <= nxt_ext;
            key_held    <= 1'b1;
            press_count <= press_count + 8'd1;
         end else if (nxt_brk && key_match) begin
            key_held    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kbd_scan_ctrl
//
// Directed bench for kbd_scan_ctrl. A table of scan bytes with the expected
// event and display state drives the main decoding cases; hand-written
// sequences cover latency, stall/overflow, counter wrap and mid-sequence
// reset. Accepted events are checked against an expected queue.
// ---------------------------------------------------------------------------
module tb_kbd_scan_ctrl;

   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       ev_ready = 1'b1;
   logic       ovf_clr = 1'b0;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_repeat;
   logic [7:0] cur_code;
   logic       key_held;
   logic [7:0] press_count;
   logic       overflow;

   kbd_scan_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk         (clk),
      .clr         (clr),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .ev_ready    (ev_ready),
      .ovf_clr     (ovf_clr),
      .ev_valid    (ev_valid),
      .ev_code     (ev_code),
      .ev_ext      (ev_ext),
      .ev_break    (ev_break),
      .ev_repeat   (ev_repeat),
      .cur_code    (cur_code),
      .key_held    (key_held),
      .press_count (press_count),
      .overflow    (overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [10:0] exp_q[$];   // {code, ext, break, repeat}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] ev(input logic [7:0] c, input logic e, input logic b, input logic r);
      return {c, e, b, r};
   endfunction

   // Handshake completes on the next rising edge when both are high here.
   always @(negedge clk) begin
      logic [10:0] want;
      if (clr && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %h expected none",
                     {ev_code, ev_ext, ev_break, ev_repeat});
         end else begin
            want = exp_q.pop_front();
            check("event", {21'd0, ev_code, ev_ext, ev_break, ev_repeat}, {21'd0, want});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      byte_valid = 1'b1;
      byte_data  = d;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      bit         has_ev;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] cur;
      logic       held;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(input logic [7:0] d, input bit h, input logic e,
                                input logic b, input logic r, input logic [7:0] c,
                                input logic hl, input logic [7:0] n);
      vec_t v;
      v.data = d; v.has_ev = h; v.ext = e; v.brk = b; v.rep = r;
      v.cur = c; v.held = hl; v.cnt = n;
      return v;
   endfunction

   initial begin
      logic [7:0] code;

      //            data   ev ext brk rep  cur   held cnt
      vecs.push_back(row(8'h1C, 1, 0, 0, 0, 8'h1C, 1, 8'd1));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd1));
      vecs.push_back(row(8'h1C, 1, 0, 1, 0, 8'h1C, 0, 8'd1));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 0, 8'd1));
      vecs.push_back(row(8'h75, 1, 1, 0, 0, 8'h75, 1, 8'd2));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h75, 1, 8'd2));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h75, 1, 8'd2));
      vecs.push_back(row(8'h75, 1, 1, 1, 0, 8'h75, 0, 8'd2));
      vecs.push_back(row(8'h1C, 1, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'h1C, 1, 0, 0, 1, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'h1C, 1, 0, 0, 1, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hAA, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hFA, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hEE, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hFE, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'h32, 1, 0, 1, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 1, 8'd3));
      vecs.push_back(row(8'h1C, 1, 1, 0, 0, 8'h1C, 1, 8'd4));
      vecs.push_back(row(8'h1C, 1, 0, 0, 0, 8'h1C, 1, 8'd5));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 1, 8'd5));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd5));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 1, 8'd5));
      vecs.push_back(row(8'h1C, 1, 1, 0, 0, 8'h1C, 1, 8'd6));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd6));
      vecs.push_back(row(8'h1C, 1, 0, 1, 0, 8'h1C, 1, 8'd6));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 1, 8'd6));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 1, 8'd6));
      vecs.push_back(row(8'h1C, 1, 1, 1, 0, 8'h1C, 0, 8'd6));
      vecs.push_back(row(8'hF0, 0, 0, 0, 0, 8'h1C, 0, 8'd6));
      vecs.push_back(row(8'hAA, 1, 0, 1, 0, 8'h1C, 0, 8'd6));
      vecs.push_back(row(8'h1C, 1, 0, 0, 0, 8'h1C, 1, 8'd7));
      vecs.push_back(row(8'hE0, 0, 0, 0, 0, 8'h1C, 1, 8'd7));
      vecs.push_back(row(8'hFA, 1, 1, 0, 0, 8'hFA, 1, 8'd8));

      // ---------------- reset ----------------
      #1;
      check("reset_state", {2'd0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
                            cur_code, key_held, press_count, overflow}, 32'd0);
      cycles(3);
      clr = 1'b1;
      cycles(1);

      // ---------------- table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].has_ev) begin
            exp_q.push_back(ev(vecs[i].data, vecs[i].ext, vecs[i].brk, vecs[i].rep));
         end
         send_byte(vecs[i].data);
         cycles(1);
         check($sformatf("status_row%0d", i),
               {15'd0, cur_code, key_held, press_count},
               {15'd0, vecs[i].cur, vecs[i].held, vecs[i].cnt});
      end

      // ---------------- latency ----------------
      exp_q.push_back(ev(8'h16, 0, 0, 0));
      send_byte(8'h16);
      check("lat_pop_cycle_valid", {31'd0, ev_valid}, 32'd0);
      cycles(1);
      check("lat_visible", {15'd0, ev_valid, ev_code, press_count},
            {15'd0, 1'b1, 8'h16, 8'd9});
      cycles(2);

      // ---------------- stall and overflow ----------------
      ev_ready = 1'b0;
      exp_q.push_back(ev(8'h15, 0, 0, 0));
      exp_q.push_back(ev(8'h1D, 0, 0, 0));
      exp_q.push_back(ev(8'h24, 0, 0, 0));
      exp_q.push_back(ev(8'h2D, 0, 0, 0));
      exp_q.push_back(ev(8'h2C, 0, 0, 0));
      send_byte(8'h15);
      send_byte(8'h1D);
      send_byte(8'h24);
      send_byte(8'h2D);
      send_byte(8'h2C);
      send_byte(8'h35);   // FIFO full, stalled: dropped
      check("stall_held_event", {20'd0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
            {20'd0, 1'b1, 8'h15, 3'b000});
      check("stall_overflow", {31'd0, overflow}, 32'd1);
      check("stall_count", {24'd0, press_count}, {24'd0, 8'd10});
      cycles(3);
      check("stall_still_held", {20'd0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat},
            {20'd0, 1'b1, 8'h15, 3'b000});

      // Drop and clear in the same cycle: overflow stays set.
      ovf_clr    = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h44;
      @(posedge clk);
      #1;
      ovf_clr    = 1'b0;
      byte_valid = 1'b0;
      check("ovf_set_wins", {31'd0, overflow}, 32'd1);

      // Release the stall while writing into the full FIFO.
      exp_q.push_back(ev(8'h3C, 0, 0, 0));
      ev_ready = 1'b1;
      send_byte(8'h3C);
      cycles(10);
      check("drain_queue_empty", exp_q.size(), 32'd0);
      check("drain_status", {15'd0, cur_code, key_held, press_count},
            {15'd0, 8'h3C, 1'b1, 8'd15});

      // ---------------- press_count wrap ----------------
      for (int i = 0; i < 240; i++) begin
         code = 8'h01 + 8'(i % 127);
         exp_q.push_back(ev(code, 0, 0, 0));
         send_byte(code);
         exp_q.push_back(ev(code, 0, 1, 0));
         send_byte(8'hF0);
         send_byte(code);
      end
      cycles(4);
      check("wrap_255", {23'd0, key_held, press_count}, {23'd0, 1'b0, 8'd255});
      exp_q.push_back(ev(8'h2A, 0, 0, 0));
      send_byte(8'h2A);
      cycles(1);
      check("wrap_zero", {15'd0, cur_code, key_held, press_count},
            {15'd0, 8'h2A, 1'b1, 8'd0});
      check("ovf_before_clr", {31'd0, overflow}, 32'd1);
      ovf_clr = 1'b1;
      cycles(1);
      ovf_clr = 1'b0;
      check("ovf_cleared", {31'd0, overflow}, 32'd0);

      // ---------------- reset mid-sequence ----------------
      send_byte(8'hE0);
      cycles(2);
      check("pre_reset_queue_empty", exp_q.size(), 32'd0);
      clr = 1'b0;
      #2;
      check("mid_reset_outputs", {2'd0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
                                  cur_code, key_held, press_count, overflow}, 32'd0);
      cycles(2);
      clr = 1'b1;
      exp_q.push_back(ev(8'h75, 0, 0, 0));
      send_byte(8'h75);
      cycles(1);
      check("post_reset_status", {15'd0, cur_code, key_held, press_count},
            {15'd0, 8'h75, 1'b1, 8'd1});
      cycles(3);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
